// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the byte-serial memory controller.
// Imported by the client-bus interface and the controller itself.
package mem_ctrl_pkg;

  localparam int          ADDR_W       = 32;
  localparam int          DATA_W       = 32;
  localparam logic [31:0] IO_BASE_ADDR = 32'h0003_0000;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2
  } mc_state_e;

  // Byte count of an LSB access; the unused encoding is treated as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Client-side bus of mem_ctrl: icache word fetch and LSB load/store handshakes.
// master = requesters (icache, LSB); slave = the memory controller.
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
);

  logic                  ic_req;
  logic [ADDR_WIDTH-1:0] ic_addr;
  logic                  ic_done;
  logic [DATA_WIDTH-1:0] ic_data;

  logic                  lsb_req;
  logic                  lsb_wr;
  logic [1:0]            lsb_size;
  logic [ADDR_WIDTH-1:0] lsb_addr;
  logic [DATA_WIDTH-1:0] lsb_wdata;
  logic                  lsb_done;
  logic [DATA_WIDTH-1:0] lsb_rdata;

  modport master (
    output ic_req, ic_addr, lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
    input  ic_done, ic_data, lsb_done, lsb_rdata
  );

  modport slave (
    input  ic_req, ic_addr, lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
    output ic_done, ic_data, lsb_done, lsb_rdata
  );

endinterface

// File: rtl/mem_ctrl.sv
// Sole master of the byte-wide RAM/IO port: arbitrates icache fetches and LSB
// accesses, serializes each into byte cycles and assembles a little-endian word.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_W,
  parameter int                    DATA_WIDTH = DATA_W,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = IO_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_flush,
  mem_ctrl_if.slave             bus,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  mc_state_e             state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  src_ic_q, src_ic_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  ic_done_q, ic_done_d;
  logic [DATA_WIDTH-1:0] ic_data_q, ic_data_d;
  logic                  lsb_done_q, lsb_done_d;
  logic [DATA_WIDTH-1:0] lsb_rdata_q, lsb_rdata_d;

  logic [ADDR_WIDTH-1:0] byte_addr;
  logic                  bubble;

  assign byte_addr = addr_q + ADDR_WIDTH'(cnt_q);
  // A requester still sees its done pulse this cycle and has not dropped req yet.
  assign bubble    = ic_done_q | lsb_done_q;

  // NOTE: every _d gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    src_ic_d    = src_ic_q;
    mem_a_d     = mem_a_q;
    mem_wr_d    = 1'b0;
    mem_dout_d  = mem_dout_q;
    ic_done_d   = 1'b0;
    ic_data_d   = ic_data_q;
    lsb_done_d  = 1'b0;
    lsb_rdata_d = lsb_rdata_q;

    case (state_q)
      MC_IDLE: begin
        if (!bubble) begin
          // On a flush edge only a committed store may start.
          if (bus.lsb_req && (bus.lsb_wr || !rob_flush)) begin
            addr_d   = bus.lsb_addr;
            nbytes_d = size_bytes(bus.lsb_size);
            wdata_d  = bus.lsb_wdata;
            src_ic_d = 1'b0;
            buf_d    = '0;
            mem_a_d  = bus.lsb_addr;
            if (bus.lsb_wr) begin
              state_d = MC_WRITE;
              if ((bus.lsb_addr >= IO_BASE) && io_buffer_full) begin
                cnt_d = 3'd0;
              end else begin
                mem_wr_d   = 1'b1;
                mem_dout_d = bus.lsb_wdata[7:0];
                cnt_d      = 3'd1;
              end
            end else begin
              state_d = MC_READ;
              cnt_d   = 3'd0;
            end
          end else if (bus.ic_req && !rob_flush) begin
            state_d  = MC_READ;
            addr_d   = bus.ic_addr;
            nbytes_d = 3'd4;
            src_ic_d = 1'b1;
            buf_d    = '0;
            mem_a_d  = bus.ic_addr;
            cnt_d    = 3'd0;
          end
        end
      end

      MC_READ: begin
        if (rob_flush) begin
          state_d = MC_IDLE;
          mem_a_d = '0;
          cnt_d   = 3'd0;
        end else begin
          // Byte cnt arrives now; drop it into its little-endian slot.
          buf_d = buf_q | (DATA_WIDTH'(mem_din) << {cnt_q, 3'b000});
          if (cnt_q == nbytes_q - 3'd1) begin
            state_d = MC_IDLE;
            mem_a_d = '0;
            cnt_d   = 3'd0;
            if (src_ic_q) begin
              ic_done_d = 1'b1;
              ic_data_d = buf_d;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = buf_d;
            end
          end else begin
            mem_a_d = addr_q + ADDR_WIDTH'(cnt_q + 3'd1);
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end

      MC_WRITE: begin
        if (cnt_q == nbytes_q) begin
          state_d    = MC_IDLE;
          mem_a_d    = '0;
          cnt_d      = 3'd0;
          lsb_done_d = 1'b1;
        end else if (!((byte_addr >= IO_BASE) && io_buffer_full)) begin
          mem_wr_d   = 1'b1;
          mem_a_d    = byte_addr;
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: state_d = MC_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= MC_IDLE;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      src_ic_q    <= 1'b0;
      mem_a_q     <= '0;
      mem_wr_q    <= 1'b0;
      mem_dout_q  <= '0;
      ic_done_q   <= 1'b0;
      ic_data_q   <= '0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      src_ic_q    <= src_ic_d;
      mem_a_q     <= mem_a_d;
      mem_wr_q    <= mem_wr_d;
      mem_dout_q  <= mem_dout_d;
      ic_done_q   <= ic_done_d;
      ic_data_q   <= ic_data_d;
      lsb_done_q  <= lsb_done_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign mem_a         = mem_a_q;
  assign mem_wr        = mem_wr_q;
  assign mem_dout      = mem_dout_q;
  assign bus.ic_done   = ic_done_q;
  assign bus.ic_data   = ic_data_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a byte RAM model plus scoreboards of expected
// RAM writes and expected done results, compared as the DUT produces them.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct packed {
    logic        is_ic;
    logic        chk_data;
    logic [31:0] data;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_flush;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  ram [0:65535];
  wr_t         wr_q[$];
  res_t        res_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          edges;

  mem_ctrl_if bus ();

  mem_ctrl dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .rob_flush      (rob_flush),
    .bus            (bus),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  // Data for the address registered at one edge is present before the next edge.
  assign mem_din = ram[mem_a[15:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, sampled 1ns later; scoreboards only see edges that rdy_in enabled.
  task automatic tick();
    bit   en;
    wr_t  w;
    res_t r;
    en = rdy_in;
    @(posedge clk);
    #1;
    if (!en) return;
    if (mem_wr) begin
      check("write_expected", 64'(wr_q.size() != 0), 64'd1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        check("write_addr", 64'(mem_a), 64'(w.a));
        check("write_data", 64'(mem_dout), 64'(w.d));
      end
    end
    if (bus.ic_done || bus.lsb_done) begin
      check("done_expected", 64'(res_q.size() != 0), 64'd1);
      if (res_q.size() != 0) begin
        r = res_q.pop_front();
        check("done_source", 64'(bus.ic_done), 64'(r.is_ic));
        if (r.chk_data)
          check("done_data", 64'(r.is_ic ? bus.ic_data : bus.lsb_rdata), 64'(r.data));
      end
    end
  endtask

  task automatic wait_done(input bit is_ic, input int max_edges, output int n);
    logic d;
    n = 0;
    do begin
      tick();
      n++;
      d = is_ic ? bus.ic_done : bus.lsb_done;
    end while (!d && n < max_edges);
    check("done_within_bound", 64'(d), 64'd1);
  endtask

  task automatic push_writes(input logic [31:0] a, input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++) wr_q.push_back('{a + 32'(i), data[8*i +: 8]});
  endtask

  task automatic lsb_issue(input logic wr, input size_e size, input logic [31:0] a,
                           input logic [31:0] wd);
    bus.lsb_req   = 1'b1;
    bus.lsb_wr    = wr;
    bus.lsb_size  = size;
    bus.lsb_addr  = a;
    bus.lsb_wdata = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
    ram[16'h0004] = 8'h80;
    ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22; ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;

    rst_in = 1'b0; rdy_in = 1'b1; rob_flush = 1'b0; io_buffer_full = 1'b0;
    bus.ic_req = 1'b0; bus.ic_addr = '0;
    bus.lsb_req = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_size = SIZE_B;
    bus.lsb_addr = '0; bus.lsb_wdata = '0;

    // Reset state
    #12;
    check("rst_mem_a", 64'(mem_a), 64'h0);
    check("rst_mem_wr", 64'(mem_wr), 64'h0);
    check("rst_mem_dout", 64'(mem_dout), 64'h0);
    check("rst_ic_done", 64'(bus.ic_done), 64'h0);
    check("rst_lsb_done", 64'(bus.lsb_done), 64'h0);
    check("rst_ic_data", 64'(bus.ic_data), 64'h0);
    check("rst_lsb_rdata", 64'(bus.lsb_rdata), 64'h0);
    rst_in = 1'b1;
    tick();

    // Icache word fetch: addresses step per edge, done on the 4th edge after grant
    bus.ic_addr = 32'h1000; bus.ic_req = 1'b1;
    res_q.push_back('{1'b1, 1'b1, 32'h0000_0513});
    tick();
    check("t1_grant_addr", 64'(mem_a), 64'h1000);
    check("t1_grant_read", 64'(mem_wr), 64'h0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("t1_addr_step", 64'(mem_a), 64'(32'h1000 + 32'(k)));
    end
    tick();
    check("t1_done", 64'(bus.ic_done), 64'h1);
    check("t1_addr_idle", 64'(mem_a), 64'h0);
    bus.ic_req = 1'b0;
    tick();
    check("t1_done_pulse", 64'(bus.ic_done), 64'h0);

    // Word store: four byte writes, done one edge after the last
    lsb_issue(1'b1, SIZE_W, 32'h2000, 32'hDEAD_BEEF);
    push_writes(32'h2000, 32'hDEAD_BEEF, 4);
    res_q.push_back('{1'b0, 1'b0, 32'h0});
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_write_cycle", 64'(mem_wr), 64'h1);
    end
    tick();
    check("t2_done", 64'(bus.lsb_done), 64'h1);
    check("t2_wr_low", 64'(mem_wr), 64'h0);
    bus.lsb_req = 1'b0;
    check("t2_all_written", 64'(wr_q.size()), 64'h0);
    tick();

    // Simultaneous requests: LSB byte load first, one bubble, then icache
    bus.ic_addr = 32'h1000; bus.ic_req = 1'b1;
    lsb_issue(1'b0, SIZE_B, 32'h0004, 32'h0);
    res_q.push_back('{1'b0, 1'b1, 32'h0000_0080});
    res_q.push_back('{1'b1, 1'b1, 32'h0000_0513});
    tick();
    check("t3_lsb_first", 64'(mem_a), 64'h0004);
    tick();
    check("t3_lsb_done", 64'(bus.lsb_done), 64'h1);
    bus.lsb_req = 1'b0;
    tick();
    check("t3_bubble", 64'(mem_a), 64'h0);
    tick();
    check("t3_ic_grant", 64'(mem_a), 64'h1000);
    wait_done(1'b1, 8, edges);
    check("t3_ic_latency", 64'(edges), 64'd4);
    bus.ic_req = 1'b0;
    tick();

    // IO store back-pressure: no write while the buffer is full, exactly one after
    io_buffer_full = 1'b1;
    lsb_issue(1'b1, SIZE_B, 32'h0003_0000, 32'h0000_0041);
    wr_q.push_back('{32'h0003_0000, 8'h41});
    res_q.push_back('{1'b0, 1'b0, 32'h0});
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_stalled", 64'(mem_wr), 64'h0);
    end
    io_buffer_full = 1'b0;
    tick();
    check("t4_released", 64'(mem_wr), 64'h1);
    tick();
    check("t4_done", 64'(bus.lsb_done), 64'h1);
    bus.lsb_req = 1'b0;
    tick();
    check("t4_no_dup", 64'(mem_wr), 64'h0);

    // Flush in the 3rd cycle of an icache read aborts it silently
    bus.ic_addr = 32'h1000; bus.ic_req = 1'b1;
    tick(); tick(); tick();
    rob_flush = 1'b1;
    tick();
    check("t5_abort_addr", 64'(mem_a), 64'h0);
    check("t5_abort_wr", 64'(mem_wr), 64'h0);
    check("t5_abort_nodone", 64'(bus.ic_done), 64'h0);
    rob_flush = 1'b0; bus.ic_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_no_late_done", 64'(bus.ic_done), 64'h0);
    end
    lsb_issue(1'b0, SIZE_B, 32'h0004, 32'h0);
    res_q.push_back('{1'b0, 1'b1, 32'h0000_0080});
    tick();
    check("t5_idle_regrant", 64'(mem_a), 64'h0004);
    tick();
    check("t5_load_done", 64'(bus.lsb_done), 64'h1);
    bus.lsb_req = 1'b0;
    tick();

    // Flush during a word store: all bytes still land
    lsb_issue(1'b1, SIZE_W, 32'h2000, 32'h1122_3344);
    push_writes(32'h2000, 32'h1122_3344, 4);
    res_q.push_back('{1'b0, 1'b0, 32'h0});
    tick(); tick();
    rob_flush = 1'b1;
    tick();
    check("t5b_write_on_flush", 64'(mem_wr), 64'h1);
    tick();
    check("t5b_write_last", 64'(mem_wr), 64'h1);
    rob_flush = 1'b0;
    tick();
    check("t5b_done", 64'(bus.lsb_done), 64'h1);
    bus.lsb_req = 1'b0;
    check("t5b_all_written", 64'(wr_q.size()), 64'h0);
    tick();

    // Flush in IDLE: load and icache ignored, store granted
    rob_flush = 1'b1;
    bus.ic_addr = 32'h1000; bus.ic_req = 1'b1;
    lsb_issue(1'b0, SIZE_B, 32'h0004, 32'h0);
    tick();
    check("t5c_ignored_addr", 64'(mem_a), 64'h0);
    check("t5c_ignored_wr", 64'(mem_wr), 64'h0);
    lsb_issue(1'b1, SIZE_B, 32'h0010, 32'h0000_005A);
    wr_q.push_back('{32'h0000_0010, 8'h5A});
    res_q.push_back('{1'b0, 1'b0, 32'h0});
    tick();
    check("t5c_store_granted", 64'(mem_wr), 64'h1);
    tick();
    check("t5c_store_done", 64'(bus.lsb_done), 64'h1);
    bus.lsb_req = 1'b0;
    tick();
    tick();
    check("t5c_ic_still_ignored", 64'(mem_a), 64'h0);
    rob_flush = 1'b0;
    res_q.push_back('{1'b1, 1'b1, 32'h0000_0513});
    tick();
    check("t5c_ic_grant", 64'(mem_a), 64'h1000);
    wait_done(1'b1, 8, edges);
    check("t5c_ic_latency", 64'(edges), 64'd4);
    bus.ic_req = 1'b0;
    tick();

    // Asynchronous reset between edges of a word store
    lsb_issue(1'b1, SIZE_W, 32'h2000, 32'hCAFE_F00D);
    push_writes(32'h2000, 32'hCAFE_F00D, 2);
    tick(); tick();
    #3 rst_in = 1'b0;
    #1;
    check("t6_rst_wr", 64'(mem_wr), 64'h0);
    check("t6_rst_addr", 64'(mem_a), 64'h0);
    check("t6_rst_dout", 64'(mem_dout), 64'h0);
    check("t6_rst_done", 64'(bus.lsb_done), 64'h0);
    bus.lsb_req = 1'b0;
    #2 rst_in = 1'b1;
    check("t6_partial_writes", 64'(wr_q.size()), 64'h0);
    bus.ic_addr = 32'h1000; bus.ic_req = 1'b1;
    res_q.push_back('{1'b1, 1'b1, 32'h0000_0513});
    // The first counted edge is the grant edge, then four more.
    wait_done(1'b1, 10, edges);
    check("t6_recover_latency", 64'(edges), 64'd5);
    bus.ic_req = 1'b0;
    tick();

    // rdy_in low for two edges in the middle of a word load
    lsb_issue(1'b0, SIZE_W, 32'h0100, 32'h0);
    res_q.push_back('{1'b0, 1'b1, 32'h4433_2211});
    tick();
    tick();
    check("t7_before_stall", 64'(mem_a), 64'h0101);
    rdy_in = 1'b0;
    tick(); tick();
    check("t7_frozen_addr", 64'(mem_a), 64'h0101);
    check("t7_frozen_nodone", 64'(bus.lsb_done), 64'h0);
    rdy_in = 1'b1;
    tick();
    check("t7_resume_addr", 64'(mem_a), 64'h0102);
    tick();
    tick();
    check("t7_done", 64'(bus.lsb_done), 64'h1);
    bus.lsb_req = 1'b0;
    tick();

    check("final_writes_drained", 64'(wr_q.size()), 64'h0);
    check("final_results_drained", 64'(res_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
